// File: rtl/pulse_ctrl_pkg.sv
// pulse_ctrl_pkg
//   Shared definitions for the toggle-encoded pulse schedulers:
//   - pulse_state_e     : arbiter state encoding (ARM, IDLE, WAIT_RET, GAP)
//   - PULSE_MIN_GAP     : default idle cycles after each completed issue
//   - PULSE_RET_TIMEOUT : default cycles allowed for splitter returns
//   - tgl_edge()        : one toggle-encoded pulse = any change of level
`timescale 1ps/100fs
package pulse_ctrl_pkg;

   typedef enum logic [1:0] {
      ARM      = 2'd0,
      IDLE     = 2'd1,
      WAIT_RET = 2'd2,
      GAP      = 2'd3
   } pulse_state_e;

   localparam int PULSE_MIN_GAP     = 2;
   localparam int PULSE_RET_TIMEOUT = 8;

   // A pulse on a toggle-encoded line is any difference from the last sampled level.
   function automatic logic tgl_edge(input logic cur, input logic prev);
      return cur ^ prev;
   endfunction

endpackage

// File: rtl/splitter_pulse_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Returns the first set bit of 'mask'
//   at or after index 'ptr', wrapping at N.
//   Ports:
//     mask   [N-1:0]    : candidate bits (1 = has work)
//     ptr    [ID_W-1:0] : starting index of the search, 0..N-1
//     winner [ID_W-1:0] : selected index (0 when nothing is valid)
//     valid             : at least one candidate bit is set
`timescale 1ps/100fs
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    mask,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] winner,
   output logic            valid
);

   // Scan offsets 0..N-1 from the pointer; the first hit wins.
   always_comb begin
      logic [ID_W:0] idx_s;
      winner = {ID_W{1'b0}};
      valid  = 1'b0;
      idx_s  = {(ID_W+1){1'b0}};
      for (int off = 0; off < N; off++) begin
         idx_s = {1'b0, ptr} + (ID_W+1)'(off);
         // ptr < N and off < N, so one subtraction is enough to wrap.
         if (idx_s >= (ID_W+1)'(N)) begin
            idx_s = idx_s - (ID_W+1)'(N);
         end else begin
            idx_s = idx_s;
         end
         if (!valid && mask[idx_s[ID_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx_s[ID_W-1:0];
         end else begin
            valid  = valid;
            winner = winner;
         end
      end
   end

endmodule

// File: rtl/splitter_pulse_arbiter.sv
// splitter_pulse_arbiter
//   Shares one splitter between NUM_REQ toggle-encoded requesters. Request
//   pulses are counted per requester and issued one at a time, round-robin,
//   as a toggle on split_in. Each issue waits for one pulse on both splitter
//   outputs (or a timeout), then MIN_GAP idle cycles before the next issue.
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     req_tgl[NUM_REQ]    : toggle-encoded request pulses
//     split_out1/2        : toggle returns from the splitter outputs
//     split_in            : toggle drive to the splitter input
//     grant_id            : requester served by the most recent issue
//     busy                : high whenever the state is not IDLE
//     err_overflow        : sticky, request lost at a saturated counter
//     err_timeout         : sticky, returns incomplete after RET_TIMEOUT
//     err_spurious        : sticky, unexpected or duplicate return edge
`timescale 1ps/100fs
module splitter_pulse_arbiter
   import pulse_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CNT_W       = 3,
   parameter int MIN_GAP     = PULSE_MIN_GAP,
   parameter int RET_TIMEOUT = PULSE_RET_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_tgl,
   input  logic                       split_out1,
   input  logic                       split_out2,
   output logic                       split_in,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       err_overflow,
   output logic                       err_timeout,
   output logic                       err_spurious
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam int TMO_W = (RET_TIMEOUT > 1) ? $clog2(RET_TIMEOUT) : 1;
   localparam int GAP_LAST_I = (MIN_GAP > 0) ? (MIN_GAP - 1) : 0;

   localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RET_TIMEOUT - 1);

   pulse_state_e state_r, state_nxt_s;

   logic [NUM_REQ-1:0] req_prev_r;
   logic               out1_prev_r, out2_prev_r;
   logic [NUM_REQ-1:0] req_edge_s;
   logic               ret1_edge_s, ret2_edge_s;

   logic [CNT_W-1:0]   cnt_r     [NUM_REQ];
   logic [CNT_W-1:0]   cnt_nxt_s [NUM_REQ];
   logic [NUM_REQ-1:0] nz_mask_s;
   logic [NUM_REQ-1:0] dec_s;
   logic               ovf_set_s;

   logic [ID_W-1:0]    ptr_r;
   logic [ID_W-1:0]    win_s;
   logic               win_valid_s;
   logic               issue_s;

   logic               flag1_r, flag2_r, flag1_nxt_s, flag2_nxt_s;
   logic [TMO_W-1:0]   tmo_r, tmo_nxt_s;
   logic [GAP_W-1:0]   gap_r, gap_nxt_s;
   logic               spur_set_s, tmo_set_s;

   logic               split_in_r;
   logic [ID_W-1:0]    grant_id_r;
   logic               busy_r;
   logic               err_overflow_r, err_timeout_r, err_spurious_r;

   assign split_in     = split_in_r;
   assign grant_id     = grant_id_r;
   assign busy         = busy_r;
   assign err_overflow = err_overflow_r;
   assign err_timeout  = err_timeout_r;
   assign err_spurious = err_spurious_r;

   // Edge detection; ARM only primes the previous-value registers, so any
   // level present when reset releases is never mistaken for a pulse.
   always_comb begin
      req_edge_s  = {NUM_REQ{1'b0}};
      ret1_edge_s = 1'b0;
      ret2_edge_s = 1'b0;
      if (state_r != ARM) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_edge_s[i] = tgl_edge(req_tgl[i], req_prev_r[i]);
         end
         ret1_edge_s = tgl_edge(split_out1, out1_prev_r);
         ret2_edge_s = tgl_edge(split_out2, out2_prev_r);
      end else begin
         req_edge_s  = {NUM_REQ{1'b0}};
         ret1_edge_s = 1'b0;
         ret2_edge_s = 1'b0;
      end
   end

   // Previous-value registers for all toggle inputs, loaded every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_r  <= {NUM_REQ{1'b0}};
         out1_prev_r <= 1'b0;
         out2_prev_r <= 1'b0;
      end else begin
         req_prev_r  <= req_tgl;
         out1_prev_r <= split_out1;
         out2_prev_r <= split_out2;
      end
   end

   // Nonzero mask of the pending counters feeds the round-robin picker.
   always_comb begin
      nz_mask_s = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         nz_mask_s[i] = |cnt_r[i];
      end
   end

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .mask   (nz_mask_s),
      .ptr    (ptr_r),
      .winner (win_s),
      .valid  (win_valid_s)
   );

   // Pending counter update: increment on request edge, decrement on issue,
   // both together cancel; a request at saturation is dropped and flagged.
   always_comb begin
      ovf_set_s = 1'b0;
      dec_s     = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         dec_s[i]     = issue_s && (win_s == ID_W'(i));
         if (req_edge_s[i] && !dec_s[i]) begin
            if (cnt_r[i] == CNT_SAT) begin
               ovf_set_s = 1'b1;
            end else begin
               cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
         end else if (dec_s[i] && !req_edge_s[i]) begin
            cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
         end else begin
            cnt_nxt_s[i] = cnt_r[i];
         end
      end
   end

   // Pending counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
      end
   end

   // Next-state and control decode for the issue / return / gap sequence.
   always_comb begin
      state_nxt_s = state_r;
      issue_s     = 1'b0;
      flag1_nxt_s = flag1_r;
      flag2_nxt_s = flag2_r;
      tmo_nxt_s   = tmo_r;
      gap_nxt_s   = gap_r;
      spur_set_s  = 1'b0;
      tmo_set_s   = 1'b0;
      case (state_r)
         ARM: begin
            state_nxt_s = IDLE;
         end
         IDLE: begin
            spur_set_s = ret1_edge_s | ret2_edge_s;
            if (win_valid_s) begin
               issue_s     = 1'b1;
               flag1_nxt_s = 1'b0;
               flag2_nxt_s = 1'b0;
               tmo_nxt_s   = {TMO_W{1'b0}};
               state_nxt_s = WAIT_RET;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_RET: begin
            // Only the first edge per output is a valid return.
            spur_set_s  = (ret1_edge_s & flag1_r) | (ret2_edge_s & flag2_r);
            flag1_nxt_s = flag1_r | ret1_edge_s;
            flag2_nxt_s = flag2_r | ret2_edge_s;
            if ((flag1_nxt_s && flag2_nxt_s) || (tmo_r == TMO_LAST)) begin
               // Completion wins over a timeout landing in the same cycle.
               tmo_set_s = !(flag1_nxt_s && flag2_nxt_s);
               gap_nxt_s = {GAP_W{1'b0}};
               if (MIN_GAP == 0) begin
                  state_nxt_s = IDLE;
               end else begin
                  state_nxt_s = GAP;
               end
            end else begin
               tmo_nxt_s   = tmo_r + TMO_W'(1'b1);
               state_nxt_s = WAIT_RET;
            end
         end
         GAP: begin
            spur_set_s = ret1_edge_s | ret2_edge_s;
            if (gap_r == GAP_LAST) begin
               state_nxt_s = IDLE;
            end else begin
               gap_nxt_s   = gap_r + GAP_W'(1'b1);
               state_nxt_s = GAP;
            end
         end
         default: begin
            state_nxt_s = ARM;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ARM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sequencing registers: return flags, timeout and gap counters, pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag1_r <= 1'b0;
         flag2_r <= 1'b0;
         tmo_r   <= {TMO_W{1'b0}};
         gap_r   <= {GAP_W{1'b0}};
         ptr_r   <= {ID_W{1'b0}};
      end else begin
         flag1_r <= flag1_nxt_s;
         flag2_r <= flag2_nxt_s;
         tmo_r   <= tmo_nxt_s;
         gap_r   <= gap_nxt_s;
         if (issue_s) begin
            ptr_r <= (win_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (win_s + ID_W'(1'b1));
         end else begin
            ptr_r <= ptr_r;
         end
      end
   end

   // Registered outputs: splitter drive, grant, busy and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         split_in_r     <= 1'b0;
         grant_id_r     <= {ID_W{1'b0}};
         busy_r         <= 1'b0;
         err_overflow_r <= 1'b0;
         err_timeout_r  <= 1'b0;
         err_spurious_r <= 1'b0;
      end else begin
         if (issue_s) begin
            split_in_r <= ~split_in_r;
            grant_id_r <= win_s;
         end else begin
            split_in_r <= split_in_r;
            grant_id_r <= grant_id_r;
         end
         busy_r         <= (state_nxt_s != IDLE);
         err_overflow_r <= err_overflow_r | ovf_set_s;
         err_timeout_r  <= err_timeout_r  | tmo_set_s;
         err_spurious_r <= err_spurious_r | spur_set_s;
      end
   end

endmodule

// File: tb/tb_splitter_pulse_arbiter.sv
`timescale 1ps/100fs
module tb_splitter_pulse_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_tgl = 4'b1111;
   logic       so1_m = 1'b0;
   logic       so2_m = 1'b0;
   logic       inj1 = 1'b0;
   logic       ret_en1 = 1'b1;
   logic       ret_en2 = 1'b1;
   logic       split_out1, split_out2;
   logic       split_in;
   logic [1:0] grant_id;
   logic       busy, err_overflow, err_timeout, err_spurious;

   int checks = 0;
   int errors = 0;

   assign split_out1 = so1_m ^ inj1;
   assign split_out2 = so2_m;

   splitter_pulse_arbiter #(
      .NUM_REQ     (4),
      .CNT_W       (3),
      .MIN_GAP     (2),
      .RET_TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_tgl      (req_tgl),
      .split_out1   (split_out1),
      .split_out2   (split_out2),
      .split_in     (split_in),
      .grant_id     (grant_id),
      .busy         (busy),
      .err_overflow (err_overflow),
      .err_timeout  (err_timeout),
      .err_spurious (err_spurious)
   );

   always #5 clk = ~clk;

   // Splitter model: each input edge reappears on both outputs 5 ps later.
   always @(split_in) begin
      #5;
      if (ret_en1) so1_m = ~so1_m;
      if (ret_en2) so2_m = ~so2_m;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ntog;
      int first_tog;
      logic prev_si;

      // Reset values while rst_n is low, request lines static high.
      step(2);
      chk("rst_split_in", split_in, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_overflow, err_timeout, err_spurious}, 0);

      // Static levels at release must not be counted.
      rst_n = 1'b1;
      step(6);
      chk("static_split_in", split_in, 0);
      chk("static_busy", busy, 0);

      // Single request on req0: issue one cycle after the sampled edge.
      req_tgl[0] = ~req_tgl[0];
      step(1);
      chk("single_no_issue_yet", split_in, 0);
      step(1);
      chk("single_split_in", split_in, 1);
      chk("single_grant", grant_id, 0);
      chk("single_busy_wait", busy, 1);
      step(2);
      chk("single_busy_gap", busy, 1);
      step(1);
      chk("single_busy_idle", busy, 0);
      chk("single_errs", {err_overflow, err_timeout, err_spurious}, 0);

      // All four at once after reset: order 0,1,2,3, spacing 4 cycles.
      do_reset();
      req_tgl = ~req_tgl;
      step(2);
      chk("rr0_grant", grant_id, 0);
      chk("rr0_split_in", split_in, 1);
      step(3);
      chk("rr_gap_hold", split_in, 1);
      chk("rr_gap_idle", busy, 0);
      step(1);
      chk("rr1_grant", grant_id, 1);
      chk("rr1_split_in", split_in, 0);
      step(4);
      chk("rr2_grant", grant_id, 2);
      chk("rr2_split_in", split_in, 1);
      step(4);
      chk("rr3_grant", grant_id, 3);
      chk("rr3_split_in", split_in, 0);
      step(4);
      chk("rr_done_busy", busy, 0);
      chk("rr_done_split_in", split_in, 0);
      chk("rr_errs", {err_overflow, err_timeout, err_spurious}, 0);

      // Overflow on req2 while req0's issue waits for a missing return 2.
      do_reset();
      ret_en2 = 1'b0;
      req_tgl[0] = ~req_tgl[0];
      step(2);
      chk("tmo_issue_split_in", split_in, 1);
      chk("tmo_issue_grant", grant_id, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            chk("tmo_not_yet", err_timeout, 0);
            chk("ovf_not_yet", err_overflow, 0);
         end
         req_tgl[2] = ~req_tgl[2];
         step(1);
      end
      chk("tmo_set", err_timeout, 1);
      chk("ovf_set", err_overflow, 1);
      chk("tmo_busy", busy, 1);
      ret_en2 = 1'b1;
      ntog = 0;
      first_tog = 0;
      prev_si = split_in;
      for (int j = 1; j <= 40; j++) begin
         step(1);
         if (split_in !== prev_si) begin
            ntog++;
            if (first_tog == 0) first_tog = j;
         end
         prev_si = split_in;
      end
      chk("ovf_issue_count", ntog, 7);
      chk("tmo_next_issue_cycle", first_tog, 3);
      chk("ovf_grant", grant_id, 2);
      chk("ovf_busy", busy, 0);
      chk("ovf_split_in", split_in, 0);
      chk("ovf_no_spurious", err_spurious, 0);

      // Return edge while IDLE is spurious and issues nothing.
      inj1 = 1'b1;
      step(1);
      chk("spur_set", err_spurious, 1);
      chk("spur_split_in", split_in, 0);
      chk("spur_busy", busy, 0);

      // Reset in WAIT_RET with three requests still pending.
      req_tgl = ~req_tgl;
      step(2);
      chk("abort_pre_split_in", split_in, 1);
      chk("abort_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_split_in", split_in, 0);
      chk("abort_grant", grant_id, 0);
      chk("abort_busy", busy, 0);
      chk("abort_errs", {err_overflow, err_timeout, err_spurious}, 0);
      step(2);
      rst_n = 1'b1;
      step(10);
      chk("post_abort_split_in", split_in, 0);
      chk("post_abort_busy", busy, 0);
      chk("post_abort_errs", {err_overflow, err_timeout, err_spurious}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
